// File: rtl/mem_port_param.sv
// rtl/mem_port_param.sv - parametrised single-port memory with byte lanes, read-latency pipeline and streaming image loader
module mem_port_param #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_DEPTH    = 4096,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int NBYTES       = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [NBYTES-1:0]     be,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  access_err,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   load_count
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    logic                  in_range;
    logic                  cpu_req;
    logic                  load_accept;
    logic                  load_final;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  err_now;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        in_range    = ({1'b0, addr} < DEPTH_W);
        cpu_req     = en & (rd_en | wr_en);
        load_accept = (state == LOAD) & load_valid;
        count_next  = load_count + 1'b1;
        load_final  = load_accept & (load_last | (count_next == DEPTH_W));
        wr_accept   = (state == IDLE) & en & wr_en & in_range;
        // a read colliding with a write is dropped, so read data never needs write bypass
        rd_accept   = (state == IDLE) & en & rd_en & ~wr_en;
        if (state == LOAD)
            err_now = cpu_req;
        else
            err_now = en & ((rd_en & wr_en) | (cpu_req & ~in_range));
        rd_word     = in_range ? mem[addr] : '0;
    end

    // Contents are never reset; writes are only blocked while reset is held so an aborted load stops cleanly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (load_accept) begin
                mem[load_count[ADDR_WIDTH-1:0]] <= load_data;
            end else if (wr_accept) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (be[b])
                        mem[addr][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    // Each stage only takes new data behind a valid, so dout holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            access_err <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++)
                pipe_data[i] <= '0;
        end else begin
            access_err    <= err_now;
            pipe_valid[0] <= rd_accept;
            if (rd_accept)
                pipe_data[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1])
                    pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign dout       = pipe_data[READ_LATENCY-1];
    assign dout_valid = pipe_valid[READ_LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        load_done  <= 1'b0;
                        load_count <= '0;
                    end
                end
                LOAD: begin
                    if (load_accept)
                        load_count <= count_next;
                    if (load_final) begin
                        state      <= IDLE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_param.sv
// tb/tb_mem_port_param.sv - directed bench for mem_port_param: default instance and a small deep-latency instance
module tb_mem_port_param;

    logic clock;
    int   checks = 0;
    int   errors = 0;

    logic        a_reset, a_en, a_rd_en, a_wr_en, a_load_start, a_load_valid, a_load_last;
    logic [11:0] a_addr;
    logic [1:0]  a_be;
    logic [15:0] a_din, a_dout, a_load_data;
    logic        a_dout_valid, a_access_err, a_load_ready, a_load_done;
    logic [12:0] a_load_count;

    logic        b_reset, b_en, b_rd_en, b_wr_en, b_load_start, b_load_valid, b_load_last;
    logic [2:0]  b_addr;
    logic [1:0]  b_be;
    logic [15:0] b_din, b_dout, b_load_data;
    logic        b_dout_valid, b_access_err, b_load_ready, b_load_done;
    logic [3:0]  b_load_count;

    mem_port_param u_a (
        .clock(clock), .reset(a_reset), .addr(a_addr), .en(a_en), .rd_en(a_rd_en),
        .wr_en(a_wr_en), .be(a_be), .din(a_din), .dout(a_dout), .dout_valid(a_dout_valid),
        .access_err(a_access_err), .load_start(a_load_start), .load_valid(a_load_valid),
        .load_data(a_load_data), .load_last(a_load_last), .load_ready(a_load_ready),
        .load_done(a_load_done), .load_count(a_load_count)
    );

    mem_port_param #(.MEM_DEPTH(6), .READ_LATENCY(3)) u_b (
        .clock(clock), .reset(b_reset), .addr(b_addr), .en(b_en), .rd_en(b_rd_en),
        .wr_en(b_wr_en), .be(b_be), .din(b_din), .dout(b_dout), .dout_valid(b_dout_valid),
        .access_err(b_access_err), .load_start(b_load_start), .load_valid(b_load_valid),
        .load_data(b_load_data), .load_last(b_load_last), .load_ready(b_load_ready),
        .load_done(b_load_done), .load_count(b_load_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        a_reset = 1; a_en = 0; a_rd_en = 0; a_wr_en = 0; a_addr = '0; a_be = '0; a_din = '0;
        a_load_start = 0; a_load_valid = 0; a_load_data = '0; a_load_last = 0;
        b_reset = 1; b_en = 0; b_rd_en = 0; b_wr_en = 0; b_addr = '0; b_be = '0; b_din = '0;
        b_load_start = 0; b_load_valid = 0; b_load_data = '0; b_load_last = 0;
        repeat (2) @(negedge clock);
        a_reset = 0; b_reset = 0;
        @(negedge clock);
        check("a_rst_dout", a_dout, 0);
        check("a_rst_valid", a_dout_valid, 0);
        check("a_rst_err", a_access_err, 0);
        check("a_rst_ready", a_load_ready, 0);
        check("a_rst_done", a_load_done, 0);
        check("a_rst_count", a_load_count, 0);
        check("b_rst_valid", b_dout_valid, 0);

        // default instance: 5-word image with load_last on the final word
        a_load_start = 1;
        @(negedge clock);
        a_load_start = 0;
        check("a_ready_load", a_load_ready, 1);
        for (int i = 0; i < 5; i++) begin
            a_load_valid = 1; a_load_data = 16'(32'h1111 * (i + 1)); a_load_last = (i == 4);
            @(negedge clock);
            if (i == 3) check("a_done_early", a_load_done, 0);
        end
        a_load_valid = 0; a_load_last = 0;
        check("a_done", a_load_done, 1);
        check("a_count", a_load_count, 5);
        check("a_ready_end", a_load_ready, 0);

        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin a_en = 1; a_rd_en = 1; a_addr = 12'(i); end
            else begin a_en = 0; a_rd_en = 0; end
            @(negedge clock);
            if (i < 5) begin
                check($sformatf("a_rd_valid%0d", i), a_dout_valid, 1);
                check($sformatf("a_rd_data%0d", i), a_dout, 32'h1111 * (i + 1));
            end else begin
                check("a_rd_idle", a_dout_valid, 0);
            end
        end
        check("a_dout_hold", a_dout, 16'h5555);

        // byte-lane write
        a_en = 1; a_wr_en = 1; a_addr = 12'd7; a_din = 16'h1234; a_be = 2'b11;
        @(negedge clock);
        a_din = 16'hABCD; a_be = 2'b01;
        @(negedge clock);
        a_wr_en = 0; a_rd_en = 1;
        @(negedge clock);
        check("a_be_valid", a_dout_valid, 1);
        check("a_be_data", a_dout, 16'h12CD);
        check("a_be_err", a_access_err, 0);

        // simultaneous read and write: write wins, read dropped
        a_rd_en = 1; a_wr_en = 1; a_addr = 12'd3; a_din = 16'hBEEF; a_be = 2'b11;
        @(negedge clock);
        check("a_rw_err", a_access_err, 1);
        check("a_rw_valid", a_dout_valid, 0);
        a_wr_en = 0;
        @(negedge clock);
        check("a_rw_rd_valid", a_dout_valid, 1);
        check("a_rw_rd_data", a_dout, 16'hBEEF);
        check("a_rw_rd_err", a_access_err, 0);
        a_en = 0; a_rd_en = 0;

        // small instance: stream 8 words into depth 6, with a CPU read during the load
        b_load_start = 1;
        @(negedge clock);
        b_load_start = 0;
        for (int i = 0; i < 8; i++) begin
            b_load_valid = 1; b_load_data = 16'(16'hA0 + i);
            if (i == 2) begin b_en = 1; b_rd_en = 1; b_addr = 3'd0; end
            else begin b_en = 0; b_rd_en = 0; end
            @(negedge clock);
            if (i == 2) check("b_load_err", b_access_err, 1);
            if (i == 4) check("b_load_no_valid", b_dout_valid, 0);
            if (i == 5) begin
                check("b_sat_ready", b_load_ready, 0);
                check("b_sat_count_at6", b_load_count, 6);
            end
        end
        b_load_valid = 0;
        check("b_sat_count", b_load_count, 6);
        check("b_sat_done", b_load_done, 1);

        // latency 3, back-to-back reads of 0,1,2
        for (int j = 0; j < 7; j++) begin
            if (j < 3) begin b_en = 1; b_rd_en = 1; b_addr = 3'(j); end
            else begin b_en = 0; b_rd_en = 0; end
            @(negedge clock);
            if (j >= 2 && j <= 4) begin
                check($sformatf("b_lat_valid%0d", j), b_dout_valid, 1);
                check($sformatf("b_lat_data%0d", j), b_dout, 32'hA0 + j - 2);
            end else begin
                check($sformatf("b_lat_idle%0d", j), b_dout_valid, 0);
            end
        end

        // out-of-range read and write
        b_en = 1; b_rd_en = 1; b_addr = 3'd7;
        @(negedge clock);
        check("b_oor_rd_err", b_access_err, 1);
        b_rd_en = 0; b_wr_en = 1; b_addr = 3'd6; b_din = 16'hFFFF; b_be = 2'b11;
        @(negedge clock);
        check("b_oor_wr_err", b_access_err, 1);
        check("b_oor_early", b_dout_valid, 0);
        b_en = 0; b_wr_en = 0;
        @(negedge clock);
        check("b_oor_valid", b_dout_valid, 1);
        check("b_oor_data", b_dout, 0);

        // reset with reads in flight
        b_en = 1; b_rd_en = 1; b_addr = 3'd4;
        @(negedge clock);
        b_addr = 3'd5;
        @(negedge clock);
        b_en = 0; b_rd_en = 0; b_reset = 1;
        @(negedge clock);
        b_reset = 0;
        check("b_rst_flush0", b_dout_valid, 0);
        check("b_rst_dout", b_dout, 0);
        check("b_rst_done", b_load_done, 0);
        check("b_rst_count", b_load_count, 0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("b_rst_flush%0d", k), b_dout_valid, 0);
        end

        // reset during a load after 3 words
        b_load_start = 1;
        @(negedge clock);
        b_load_start = 0;
        for (int i = 0; i < 3; i++) begin
            b_load_valid = 1; b_load_data = 16'(16'hD0 + i);
            @(negedge clock);
        end
        check("b_abort_count3", b_load_count, 3);
        check("b_abort_ready", b_load_ready, 1);
        b_load_valid = 0; b_reset = 1;
        @(negedge clock);
        b_reset = 0;
        check("b_abort_done", b_load_done, 0);
        check("b_abort_count", b_load_count, 0);
        check("b_abort_ready0", b_load_ready, 0);
        for (int j = 0; j < 4; j++) begin
            if (j < 2) begin b_en = 1; b_rd_en = 1; b_addr = 3'(2 + j); end
            else begin b_en = 0; b_rd_en = 0; end
            @(negedge clock);
            if (j == 2) check("b_abort_addr2", b_dout, 16'hD2);
            if (j == 3) check("b_abort_addr3", b_dout, 16'hA3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
